// File: rtl/serial_twos_complement.sv
// Bit-serial two's-complement negator for LSB-first streams: bits pass through
// up to and including the first 1, every later bit of the word is inverted.
module serial_twos_complement (
    input  logic i,
    input  logic r,
    input  logic clk,
    output logic y
);

    typedef enum logic {
        S0 = 1'b0,  // no 1 consumed yet in this word
        S1 = 1'b1   // a 1 has been consumed; invert from here on
    } state_t;

    // Power-up value keeps y defined before the first reset pulse.
    state_t seen_q = S0;
    state_t seen_d;

    always_comb begin
        seen_d = seen_q;
        if (seen_q == S0 && i) begin
            seen_d = S1;
        end
    end

    // r doubles as the word delimiter, so it must clear the state without a clock.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            seen_q <= S0;
        end else begin
            seen_q <= seen_d;
        end
    end

    // Mealy output: the current bit is negated in the same cycle it arrives.
    assign y = i ^ (seen_q == S1);

endmodule

// File: tb/tb_serial_twos_complement.sv
// Scoreboarded bench for serial_twos_complement: directed words from the test
// plan plus random words checked against an arithmetic negation model.
module tb_serial_twos_complement;

    logic clk;
    logic r_tb;
    logic i_tb;
    logic y_dut;

    typedef struct {
        logic  exp;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: value and length of the current word so far.
    longint unsigned word_val = 0;
    int              word_len = 0;

    serial_twos_complement dut (
        .i   (i_tb),
        .r   (r_tb),
        .clk (clk),
        .y   (y_dut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: y is sampled mid-cycle, well away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (y_dut !== e.exp) begin
                    failures++;
                    $display("FAIL %s: y=%b expected=%b (i=%b r=%b)",
                             e.name, y_dut, e.exp, i_tb, r_tb);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        word_val = 0;
        word_len = 0;
    endfunction

    // Bit n of the output is bit n of -(bits 0..n of the word), computed by
    // plain arithmetic; the following clock edge appends the bit to the word.
    function automatic logic model_step(input logic bi, input logic br);
        longint unsigned v;
        longint unsigned neg;
        logic            res;
        if (!br) begin
            model_reset();
            return bi;
        end
        v   = word_val | (longint'(bi) << word_len);
        neg = -v;
        res = neg[word_len];
        word_val = v;
        word_len++;
        return res;
    endfunction

    // One transaction per cycle: optional reset pulse with no clock edge inside
    // it, then present i/r and queue the expected y.
    task automatic cyc(input logic bi, input logic br, input logic pulse,
                       input logic exp, input string name);
        exp_t e;
        @(posedge clk);
        #2;
        if (pulse) begin
            r_tb = 1'b0;
            #1;
        end
        i_tb  = bi;
        r_tb  = br;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic run_word(input string name, input int n,
                            input logic [15:0] ibits, input logic [15:0] ebits);
        for (int k = 0; k < n; k++) begin
            cyc(ibits[k], 1'b1, (k == 0), ebits[k], $sformatf("%s_b%0d", name, k));
        end
        $display("word %s len=%0d in=%b exp=%b", name, n, ibits[3:0], ebits[3:0]);
    endtask

    initial begin
        int n_words;
        int len;
        logic bi;
        logic br;
        logic ex;

        r_tb = 1'b1;
        i_tb = 1'b0;

        // No reset yet: power-up state must behave as S0.
        for (int k = 0; k < 5; k++) begin
            bi = (k == 2 || k == 4);
            ex = (k == 2 || k == 3);
            cyc(bi, 1'b1, 1'b0, ex, $sformatf("powerup_b%0d", k));
        end
        $display("word powerup len=5 in=10100 exp=01100");

        // Bits listed MSB..LSB in the literals; bit 0 is sent first.
        run_word("neg4",    4, 16'b0100, 16'b1100);
        run_word("neg15",   4, 16'b1111, 16'b0001);
        run_word("zero",    4, 16'b0000, 16'b0000);
        run_word("minval",  4, 16'b1000, 16'b1000);

        // Sticky S1, then asynchronous reset between edges and held reset.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, "sticky_b0");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "sticky_b1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "sticky_b2");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "async_rst_i1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "hold_rst_i0");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "hold_rst_i1");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "hold_rst_i1_edge");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "release_b0");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "release_b1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "release_b2");
        $display("word sticky_reset len=10 done");

        // Random words with occasional held-reset cycles mid-word.
        n_words = 40;
        for (int w = 0; w < n_words; w++) begin
            len = $urandom_range(1, 40);
            model_reset();
            for (int k = 0; k < len; k++) begin
                bi = ($urandom_range(0, 3) == 0);
                br = ($urandom_range(0, 15) != 0);
                ex = model_step(bi, br);
                cyc(bi, br, (k == 0), ex, $sformatf("rand_w%0d_b%0d", w, k));
            end
            $display("word rand_w%0d len=%0d", w, len);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
